// File: rtl/fighter_action_ctrl_if.sv
// -----------------------------------------------------------------------------
// fighter_action_ctrl_if
// Signal bundle between one fighter's action sequencer and the rest of the game.
//   keycode_0..3  [7:0]  current keyboard keycodes (up to four keys held)
//   GamePlaying          1 = round in progress
//   Airborne             1 = fighter is mid-jump
//   HitIn                opponent's live hitbox overlapped this fighter this frame
//   MoveEnable           1 = walk/crouch/jump keys may act
//   AttackActive         1 = this fighter's hitbox is live
//   AttackType    [1:0]  0 none, 1 punch, 2 kick
//   Knockback     [31:0] signed px/frame added to the fighter's X position
//   ActState      [2:0]  current sequencer state, for the sprite selector
// master: the game side (drives keys/status, reads the action outputs).
// slave : the sequencer itself.
// -----------------------------------------------------------------------------
interface fighter_action_ctrl_if;
    logic [7:0]         keycode_0;
    logic [7:0]         keycode_1;
    logic [7:0]         keycode_2;
    logic [7:0]         keycode_3;
    logic               GamePlaying;
    logic               Airborne;
    logic               HitIn;
    logic               MoveEnable;
    logic               AttackActive;
    logic [1:0]         AttackType;
    logic signed [31:0] Knockback;
    logic [2:0]         ActState;

    modport master (
        output keycode_0, keycode_1, keycode_2, keycode_3,
        output GamePlaying, Airborne, HitIn,
        input  MoveEnable, AttackActive, AttackType, Knockback, ActState
    );

    modport slave (
        input  keycode_0, keycode_1, keycode_2, keycode_3,
        input  GamePlaying, Airborne, HitIn,
        output MoveEnable, AttackActive, AttackType, Knockback, ActState
    );
endinterface

// File: rtl/fighter_action_ctrl.sv
// -----------------------------------------------------------------------------
// fighter_action_ctrl
// Per-fighter action sequencer. Decodes punch/kick key presses, runs each
// attack through startup/active/recovery phases counted in frames, and puts
// the fighter into hitstun (with knockback) when the opponent connects.
// Ports:
//   frame_clk  frame-rate clock (vsync); one edge per frame
//   Reset      asynchronous, active-high reset
//   fa         fighter_action_ctrl_if.slave (keys, status in; action outputs)
// -----------------------------------------------------------------------------
module fighter_action_ctrl #(
    parameter logic [7:0]  PUNCH_KEY      = 8'h11,
    parameter logic [7:0]  KICK_KEY       = 8'h10,
    parameter int unsigned PUNCH_STARTUP  = 3,
    parameter int unsigned PUNCH_ACTIVE   = 2,
    parameter int unsigned PUNCH_RECOVER  = 6,
    parameter int unsigned KICK_STARTUP   = 5,
    parameter int unsigned KICK_ACTIVE    = 3,
    parameter int unsigned KICK_RECOVER   = 10,
    parameter int unsigned HITSTUN_FRAMES = 12,
    parameter int          KNOCKBACK_PX   = 3
) (
    input logic                 frame_clk,
    input logic                 Reset,
    fighter_action_ctrl_if.slave fa
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STARTUP = 3'd1,
        S_ACTIVE  = 3'd2,
        S_RECOVER = 3'd3,
        S_HITSTUN = 3'd4
    } act_state_e;

    typedef enum logic [1:0] {
        ATK_NONE  = 2'd0,
        ATK_PUNCH = 2'd1,
        ATK_KICK  = 2'd2
    } atk_type_e;

    // Phase counters are loaded with LEN-1 so that a phase spans exactly LEN
    // frames: LEN-1 decrementing edges plus the edge that sees zero and advances.
    localparam logic [7:0] PUNCH_STARTUP_M1 = 8'(PUNCH_STARTUP - 1);
    localparam logic [7:0] PUNCH_ACTIVE_M1  = 8'(PUNCH_ACTIVE - 1);
    localparam logic [7:0] PUNCH_RECOVER_M1 = 8'(PUNCH_RECOVER - 1);
    localparam logic [7:0] KICK_STARTUP_M1  = 8'(KICK_STARTUP - 1);
    localparam logic [7:0] KICK_ACTIVE_M1   = 8'(KICK_ACTIVE - 1);
    localparam logic [7:0] KICK_RECOVER_M1  = 8'(KICK_RECOVER - 1);
    localparam logic [7:0] HITSTUN_M1       = 8'(HITSTUN_FRAMES - 1);

    act_state_e state, state_nxt;
    atk_type_e  atk_type, atk_type_nxt;
    logic [7:0] phase_cnt, phase_cnt_nxt;
    logic       punch_prev, kick_prev;
    logic       punch_now, kick_now;
    logic       punch_edge, kick_edge;

    // A key counts as pressed if it appears in any of the four keycode slots.
    assign punch_now = (fa.keycode_0 == PUNCH_KEY) || (fa.keycode_1 == PUNCH_KEY) ||
                       (fa.keycode_2 == PUNCH_KEY) || (fa.keycode_3 == PUNCH_KEY);
    assign kick_now  = (fa.keycode_0 == KICK_KEY)  || (fa.keycode_1 == KICK_KEY)  ||
                       (fa.keycode_2 == KICK_KEY)  || (fa.keycode_3 == KICK_KEY);

    // Only a fresh press starts an attack; holding the key never repeats it.
    assign punch_edge = punch_now && !punch_prev;
    assign kick_edge  = kick_now  && !kick_prev;

    // State register. The previous-key flops sample every edge regardless of
    // state, so a press made while busy or airborne is consumed, not buffered.
    always_ff @(posedge frame_clk or posedge Reset) begin
        // NOTE: every flop here has a reset value and is written with
        // non-blocking assignments so all of them update from the same
        // pre-edge values.
        if (Reset) begin
            state      <= S_IDLE;
            phase_cnt  <= '0;
            atk_type   <= ATK_NONE;
            punch_prev <= 1'b0;
            kick_prev  <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase_cnt  <= phase_cnt_nxt;
            atk_type   <= atk_type_nxt;
            punch_prev <= punch_now;
            kick_prev  <= kick_now;
        end
    end

    // Next-state logic. Priority: round stopped > being hit > new attack >
    // phase counting.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt;
        atk_type_nxt  = atk_type;

        if (!fa.GamePlaying) begin
            state_nxt     = S_IDLE;
            phase_cnt_nxt = '0;
            atk_type_nxt  = ATK_NONE;
        end else if (fa.HitIn) begin
            // Any hit, including a trade during ACTIVE or a re-hit in
            // HITSTUN, restarts the full hitstun.
            state_nxt     = S_HITSTUN;
            phase_cnt_nxt = HITSTUN_M1;
            atk_type_nxt  = ATK_NONE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!fa.Airborne && punch_edge) begin
                        state_nxt     = S_STARTUP;
                        phase_cnt_nxt = PUNCH_STARTUP_M1;
                        atk_type_nxt  = ATK_PUNCH;
                    end else if (!fa.Airborne && kick_edge) begin
                        state_nxt     = S_STARTUP;
                        phase_cnt_nxt = KICK_STARTUP_M1;
                        atk_type_nxt  = ATK_KICK;
                    end
                end
                S_STARTUP: begin
                    if (phase_cnt != 8'd0) begin
                        phase_cnt_nxt = phase_cnt - 8'd1;
                    end else begin
                        state_nxt     = S_ACTIVE;
                        phase_cnt_nxt = (atk_type == ATK_KICK) ? KICK_ACTIVE_M1 : PUNCH_ACTIVE_M1;
                    end
                end
                S_ACTIVE: begin
                    if (phase_cnt != 8'd0) begin
                        phase_cnt_nxt = phase_cnt - 8'd1;
                    end else begin
                        state_nxt     = S_RECOVER;
                        phase_cnt_nxt = (atk_type == ATK_KICK) ? KICK_RECOVER_M1 : PUNCH_RECOVER_M1;
                    end
                end
                S_RECOVER, S_HITSTUN: begin
                    if (phase_cnt != 8'd0) begin
                        phase_cnt_nxt = phase_cnt - 8'd1;
                    end else begin
                        state_nxt    = S_IDLE;
                        atk_type_nxt = ATK_NONE;
                    end
                end
                default: begin
                    state_nxt     = S_IDLE;
                    phase_cnt_nxt = '0;
                    atk_type_nxt  = ATK_NONE;
                end
            endcase
        end
    end

    // Moore output decode of the registered state.
    always_comb begin
        fa.MoveEnable   = (state == S_IDLE);
        fa.AttackActive = (state == S_ACTIVE);
        fa.AttackType   = atk_type;
        fa.Knockback    = (state == S_HITSTUN) ? 32'(KNOCKBACK_PX) : 32'sd0;
        fa.ActState     = state;
    end

endmodule

// File: tb/tb_fighter_action_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fighter_action_ctrl
// Drives fighter_action_ctrl with directed scenarios and random frames; every
// frame the outputs are compared against a timeline model that tracks "which
// action started how many frames ago" rather than per-phase down-counters.
// -----------------------------------------------------------------------------
module tb_fighter_action_ctrl;

    localparam logic [7:0] PUNCH_KEY = 8'h11;
    localparam logic [7:0] KICK_KEY  = 8'h10;
    localparam int P_S = 3, P_A = 2, P_R = 6;
    localparam int K_S = 5, K_A = 3, K_R = 10;
    localparam int HIT_LEN = 12;
    localparam int KB_PX   = 3;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;

    fighter_action_ctrl_if fa_if ();

    fighter_action_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .fa        (fa_if)
    );

    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_mode: 0 = nothing going on, 1 = attack in progress, 2 = hitstun.
    // m_age : edges elapsed since the current action began.
    int m_mode = 0;
    int m_age  = 0;
    int m_type = 0;
    bit m_pprev = 0;
    bit m_kprev = 0;

    function automatic bit key_down(input logic [7:0] key);
        return (fa_if.keycode_0 == key) || (fa_if.keycode_1 == key) ||
               (fa_if.keycode_2 == key) || (fa_if.keycode_3 == key);
    endfunction

    function automatic int action_len();
        if (m_mode == 2) return HIT_LEN;
        if (m_type == 1) return P_S + P_A + P_R;
        return K_S + K_A + K_R;
    endfunction

    function automatic int exp_state();
        int s_len, a_len;
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 4;
        s_len = (m_type == 1) ? P_S : K_S;
        a_len = (m_type == 1) ? P_A : K_A;
        if (m_age < s_len) return 1;
        if (m_age < s_len + a_len) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_age = 0; m_type = 0; m_pprev = 0; m_kprev = 0;
    endtask

    task automatic model_step();
        bit p, k, pe, ke, idle;
        p    = key_down(PUNCH_KEY);
        k    = key_down(KICK_KEY);
        pe   = p && !m_pprev;
        ke   = k && !m_kprev;
        idle = (m_mode == 0);
        if (!fa_if.GamePlaying) begin
            m_mode = 0; m_type = 0; m_age = 0;
        end else if (fa_if.HitIn) begin
            m_mode = 2; m_type = 0; m_age = 0;
        end else if (idle && !fa_if.Airborne && pe) begin
            m_mode = 1; m_type = 1; m_age = 0;
        end else if (idle && !fa_if.Airborne && ke) begin
            m_mode = 1; m_type = 2; m_age = 0;
        end else if (m_mode != 0) begin
            m_age++;
            if (m_age >= action_len()) begin
                m_mode = 0; m_type = 0; m_age = 0;
            end
        end
        m_pprev = p;
        m_kprev = k;
    endtask

    task automatic compare_all();
        int s;
        s = exp_state();
        check("ActState",     32'(fa_if.ActState),     32'(s));
        check("MoveEnable",   32'(fa_if.MoveEnable),   32'(s == 0));
        check("AttackActive", 32'(fa_if.AttackActive), 32'(s == 2));
        check("AttackType",   32'(fa_if.AttackType),   32'(m_type));
        check("Knockback",    fa_if.Knockback,         (s == 4) ? 32'(KB_PX) : 32'd0);
    endtask

    // One frame: edge, advance model with the inputs the DUT sampled, then
    // compare 1 time unit after the edge.
    task automatic tick();
        @(posedge frame_clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_keys(input logic [7:0] k0, input logic [7:0] k1,
                            input logic [7:0] k2, input logic [7:0] k3);
        fa_if.keycode_0 = k0;
        fa_if.keycode_1 = k1;
        fa_if.keycode_2 = k2;
        fa_if.keycode_3 = k3;
    endtask

    function automatic logic [7:0] rand_key();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 2) return PUNCH_KEY;
        if (r < 4) return KICK_KEY;
        if (r < 8) return 8'h00;
        return 8'($urandom);
    endfunction

    int punch_exp[12] = '{1, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 0};
    int obs[20];
    int starts;
    int prev_s;
    int run_len;

    initial begin
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        fa_if.GamePlaying = 1'b1;
        fa_if.Airborne    = 1'b0;
        fa_if.HitIn       = 1'b0;
        model_reset();

        // Reset state held across edges.
        repeat (2) @(posedge frame_clk);
        #1;
        check("rst_state", 32'(fa_if.ActState),     32'd0);
        check("rst_move",  32'(fa_if.MoveEnable),   32'd1);
        check("rst_atk",   32'(fa_if.AttackActive), 32'd0);
        check("rst_type",  32'(fa_if.AttackType),   32'd0);
        check("rst_kb",    fa_if.Knockback,         32'd0);
        @(negedge frame_clk);
        Reset = 1'b0;
        repeat (2) tick();

        // Punch timeline.
        set_keys(PUNCH_KEY, 8'h00, 8'h00, 8'h00);
        tick();
        obs[0] = int'(fa_if.ActState);
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 1; i < 12; i++) begin
            tick();
            obs[i] = int'(fa_if.ActState);
            if (i == 3) check("punch_type_active", 32'(fa_if.AttackType), 32'd1);
        end
        for (int i = 0; i < 12; i++) check("punch_seq", 32'(obs[i]), 32'(punch_exp[i]));

        // Holding the punch key for 40 frames yields one punch only.
        set_keys(8'h00, PUNCH_KEY, 8'h00, 8'h00);
        starts = 0;
        prev_s = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (fa_if.ActState == 3'd1 && prev_s != 1) starts++;
            prev_s = int'(fa_if.ActState);
        end
        check("hold_one_punch", 32'(starts), 32'd1);
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        set_keys(8'h00, PUNCH_KEY, 8'h00, 8'h00);
        tick();
        check("repress_punch", 32'(fa_if.ActState), 32'd1);
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (14) tick();

        // Same-frame punch and kick: punch wins.
        set_keys(PUNCH_KEY, 8'h00, KICK_KEY, 8'h00);
        tick();
        check("tie_type", 32'(fa_if.AttackType), 32'd1);
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (14) tick();

        // Kick alone: ACTIVE on the 6th..8th frames after the press edge.
        set_keys(8'h00, 8'h00, 8'h00, KICK_KEY);
        tick();
        obs[0] = int'(fa_if.ActState);
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        for (int i = 1; i < 19; i++) begin
            tick();
            obs[i] = int'(fa_if.ActState);
        end
        check("kick_startup_end", 32'(obs[4]),  32'd1);
        check("kick_active_0",    32'(obs[5]),  32'd2);
        check("kick_active_2",    32'(obs[7]),  32'd2);
        check("kick_recover_0",   32'(obs[8]),  32'd3);
        check("kick_idle",        32'(obs[18]), 32'd0);
        tick();

        // Hit during RECOVER: 12 frames of hitstun with knockback.
        set_keys(PUNCH_KEY, 8'h00, 8'h00, 8'h00);
        tick();
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (5) tick();
        check("in_recover", 32'(fa_if.ActState), 32'd3);
        fa_if.HitIn = 1'b1;
        tick();
        fa_if.HitIn = 1'b0;
        run_len = 0;
        for (int i = 0; i < 20 && fa_if.ActState == 3'd4; i++) begin
            if (fa_if.Knockback == 32'sd3) run_len++;
            tick();
        end
        check("hitstun_kb_frames", 32'(run_len), 32'd12);
        check("after_hitstun", 32'(fa_if.ActState), 32'd0);

        // Re-hit at hitstun frame 5 restarts a full 12 frames.
        fa_if.HitIn = 1'b1;
        tick();
        fa_if.HitIn = 1'b0;
        repeat (4) tick();
        fa_if.HitIn = 1'b1;
        tick();
        fa_if.HitIn = 1'b0;
        run_len = 0;
        for (int i = 0; i < 20 && fa_if.ActState == 3'd4; i++) begin
            run_len++;
            tick();
        end
        check("rehit_frames", 32'(run_len), 32'd12);

        // Airborne press is discarded.
        fa_if.Airborne = 1'b1;
        set_keys(8'h00, 8'h00, PUNCH_KEY, 8'h00);
        tick();
        check("airborne_idle", 32'(fa_if.ActState), 32'd0);
        fa_if.Airborne = 1'b0;
        tick();
        check("airborne_no_buffer", 32'(fa_if.ActState), 32'd0);
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        tick();

        // Round stops mid-kick.
        set_keys(KICK_KEY, 8'h00, 8'h00, 8'h00);
        tick();
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (6) tick();
        fa_if.GamePlaying = 1'b0;
        tick();
        check("gp_off_idle", 32'(fa_if.ActState), 32'd0);
        check("gp_off_type", 32'(fa_if.AttackType), 32'd0);
        fa_if.GamePlaying = 1'b1;
        tick();

        // Asynchronous reset in the middle of ACTIVE.
        set_keys(PUNCH_KEY, 8'h00, 8'h00, 8'h00);
        tick();
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) tick();
        check("pre_rst_active", 32'(fa_if.AttackActive), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_state", 32'(fa_if.ActState),     32'd0);
        check("async_rst_atk",   32'(fa_if.AttackActive), 32'd0);
        check("async_rst_move",  32'(fa_if.MoveEnable),   32'd1);
        @(posedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;
        model_reset();
        repeat (2) tick();

        // Random frames against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0)
                set_keys(rand_key(), rand_key(), rand_key(), rand_key());
            fa_if.GamePlaying = ($urandom_range(0, 49) != 0);
            fa_if.Airborne    = ($urandom_range(0, 5) == 0);
            fa_if.HitIn       = ($urandom_range(0, 24) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
